// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM hidden-unit datapath: FSM encoding and
// default word width / clamp rail.
package rbm_pkg;

  localparam int BITLENGTH_DEF = 16;
  localparam logic [BITLENGTH_DEF-1:0] INF = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add_stage.sv
// Combinational saturating signed add. Rails are symmetric (+INF / -INF) so
// the most negative code is never produced by a clamp.
module sat_add_stage #(
  parameter int W = rbm_pkg::BITLENGTH_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] z,
  output logic         clamp
);

  localparam logic [W-1:0] POS_RAIL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_RAIL = {1'b1, {(W-2){1'b0}}, 1'b1};

  logic [W-1:0] t;
  logic         pos_ovf, neg_ovf;

  assign t       = x + y;
  assign pos_ovf = ~x[W-1] & ~y[W-1] &  t[W-1];
  assign neg_ovf =  x[W-1] &  y[W-1] & ~t[W-1];
  assign clamp   = pos_ovf | neg_ovf;

  always_comb begin
    z = t;
    if (pos_ovf)      z = POS_RAIL;
    else if (neg_ovf) z = NEG_RAIL;
  end

endmodule

// File: rtl/rbm_dot_accum.sv
// Streams N_VIS weight/visible-bit terms into a saturating accumulator seeded
// with the bias, then presents the sum until the activation stage takes it.
module rbm_dot_accum
  import rbm_pkg::*;
#(
  parameter int BITLENGTH = BITLENGTH_DEF,
  parameter int N_VIS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BITLENGTH-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITLENGTH-1:0] w,
  input  logic                 v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITLENGTH-1:0] sum,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam int CW = $clog2(N_VIS);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BITLENGTH-1:0] acc, add_z;
  logic                 add_clamp;
  logic                 beat, last_beat;

  sat_add_stage #(.W(BITLENGTH)) u_sat_add (
    .x     (acc),
    .y     (w),
    .z     (add_z),
    .clamp (add_clamp)
  );

  assign beat      = (state == ACCUM) & in_valid;
  assign last_beat = beat & (cnt == CW'(N_VIS-1));

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // acc/sat_flag are only reloaded by a start in IDLE, so they hold past DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= bias;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (beat) begin
      if (v) begin
        acc      <= add_z;
        sat_flag <= sat_flag | add_clamp;
      end
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rbm_dot_accum.sv
// Directed and randomized frames for rbm_dot_accum (N_VIS=4) checked against
// an integer-arithmetic reference of the saturating dot product.
module tb_rbm_dot_accum;

  localparam int BL = 16;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BL-1:0] bias = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BL-1:0] w = '0;
  logic          v = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BL-1:0] sum;
  logic          sat_flag;
  logic          busy;

  int errors = 0;
  int checks = 0;

  rbm_dot_accum #(.BITLENGTH(BL), .N_VIS(NV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .w(w), .v(v),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True-integer reference: the sum is clamped whenever it leaves 16-bit range.
  task automatic model(input logic [BL-1:0] b, input logic [NV-1:0][BL-1:0] ws,
                       input logic [NV-1:0] vs, output logic [BL-1:0] s, output logic f);
    int a, t;
    a = int'($signed(b));
    f = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (vs[i]) begin
        t = a + int'($signed(ws[i]));
        if (t > 32767)       begin a = 32767;  f = 1'b1; end
        else if (t < -32768) begin a = -32767; f = 1'b1; end
        else                 a = t;
      end
    end
    s = BL'(a);
  endtask

  task automatic run_frame(input string tag, input logic [BL-1:0] b,
                           input logic [NV-1:0][BL-1:0] ws, input logic [NV-1:0] vs,
                           input int gap, input int hold, input bit poke_start,
                           input bit chk_lat);
    logic [BL-1:0] es;
    logic          ef;
    int            cyc;
    model(b, ws, vs, es, ef);
    @(posedge clk); #1;
    start = 1'b1; bias = b;
    @(posedge clk); #1;
    start = 1'b0; bias = $urandom;
    cyc = 1;
    for (int i = 0; i < NV; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; w = $urandom; v = $urandom;
        @(negedge clk);
        chk({tag, "_gap_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b1; w = ws[i]; v = vs[i];
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; w = $urandom; v = $urandom;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (chk_lat) chk({tag, "_latency"}, 32'(cyc), 32'(NV + 1));
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 1) begin start = 1'b1; bias = $urandom; end
      @(negedge clk);
      chk({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, es});
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, ef});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    if (poke_start) start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    chk({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum_held"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_sat_held"}, {31'd0, sat_flag}, {31'd0, ef});
    if (poke_start) begin
      // start coincident with out_ready must not open a new frame
      @(posedge clk); #1;
      chk({tag, "_start_dropped"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [NV-1:0][BL-1:0] ws;
    logic [BL-1:0]         b;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sat", {31'd0, sat_flag}, 32'd0);
    rst_n = 1'b1;

    ws = {16'd4, 16'd3, 16'd2, 16'd1};
    run_frame("t1", 16'd10, ws, 4'b1111, 0, 0, 0, 1);
    chk("t1_abs_sum", {16'd0, sum}, 32'd20);

    ws = {16'd400, 16'd300, 16'd200, 16'd100};
    run_frame("t2", 16'd0, ws, 4'b0101, 0, 0, 0, 0);
    chk("t2_abs_sum", {16'd0, sum}, 32'd400);

    ws = {16'd0, -16'sd1000, 16'd500, 16'd500};
    run_frame("t3", 16'd32000, ws, 4'b1111, 0, 0, 0, 0);
    chk("t3_abs_sum", {16'd0, sum}, 32'd31767);

    ws = {4{-16'sd1000}};
    run_frame("t4", -16'sd32000, ws, 4'b1111, 0, 0, 0, 0);
    chk("t4_abs_sum", {16'd0, sum}, 32'h8001);
    chk("t4_abs_sat", {31'd0, sat_flag}, 32'd1);

    ws = {16'd7, -16'sd20, 16'd13, 16'd50};
    run_frame("t5", 16'd5, ws, 4'b1111, 3, 5, 1, 0);

    // reset mid-frame after two beats
    @(posedge clk); #1;
    start = 1'b1; bias = 16'd10;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; w = 16'd1; v = 1'b1;
    @(posedge clk); #1;
    w = 16'd2;
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_sum", {16'd0, sum}, 32'd0);
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ws = {16'd4, 16'd3, 16'd2, 16'd1};
    run_frame("t6", 16'd10, ws, 4'b1111, 0, 0, 0, 1);
    chk("t6_abs_sum", {16'd0, sum}, 32'd20);

    for (int r = 0; r < 12; r++) begin
      b = (r % 3 == 0) ? 16'(32'($urandom_range(0, 2000)) + 30000)
        : (r % 3 == 1) ? 16'(-(32'($urandom_range(0, 2000)) + 30000)) : 16'($urandom);
      for (int i = 0; i < NV; i++) ws[i] = $urandom;
      run_frame("rnd", b, ws, 4'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
